// File: rtl/rr_arbiter_4ch.sv
// rr_arbiter_4ch: 4-channel round-robin arbiter; req[3:0] in, registered grant_idx[1:0]/grant_valid/grant_start out, MAX_HOLD preemption
module rr_arbiter_4ch #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       grant_start
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] hold_max = CNT_W'(MAX_HOLD);
  state_t state, state_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic [1:0] idx_n;
  logic [3:0] own_mask;
  logic start_n, own, others, preempt, new_grant;
  if (MAX_HOLD >= 2**CNT_W) begin : g_bad
    $error("MAX_HOLD must be < 2**CNT_W");
  end
  function automatic logic [1:0] nxt(input logic [1:0] p, input logic [3:0] r);
    logic [1:0] q;
    nxt = p;
    for (int j = 3; j >= 1; j--) begin
      q = p + 2'(j);
      if (r[q]) nxt = q;
    end
  endfunction
  assign own_mask = 4'b0001 << grant_idx;
  assign own = |(req & own_mask);
  assign others = |(req & ~own_mask);
  assign preempt = (state == GRANT) && own && (MAX_HOLD != 0) && (hold_cnt == hold_max) && others;
  assign new_grant = (|req) && ((state == IDLE) || !own || preempt);
  assign grant_valid = state == GRANT;
  always_comb begin
    state_n = (|req) ? GRANT : IDLE;
    idx_n = new_grant ? nxt(grant_idx, preempt ? (req & ~own_mask) : req) : grant_idx;
    start_n = new_grant;
    cnt_n = new_grant ? CNT_W'(1) :
            ((state == GRANT) && own) ? ((hold_cnt >= hold_max) ? hold_max : hold_cnt + CNT_W'(1)) :
            hold_cnt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_idx <= 2'b11;
      grant_start <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state <= state_n;
      grant_idx <= idx_n;
      grant_start <= start_n;
      hold_cnt <= cnt_n;
    end
  end
endmodule
